// File: rtl/deser_link_ctrl.sv
// Round-robin byte sequencer: serialises a requester's byte into the deserializer,
// forwards the recovered byte downstream and flags loopback mismatches.
// Optional WAIT_RDY watchdog: define DESER_LINK_WDOG_EN.
module deser_link_ctrl #(
    parameter int N_REQ    = 4,
    parameter int SRC_W    = $clog2(N_REQ),
    parameter int WDOG_CYC = 64
) (
    input  logic                 clock_100KHz,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     grant,
    input  logic                 des_status,
    output logic                 des_data_in,
    output logic                 des_write_in,
    input  logic                 des_data_ready,
    input  logic [7:0]           des_data_out,
    output logic                 des_ack,
    input  logic                 q_full,
    output logic                 q_push,
    output logic [7:0]           q_data,
    output logic [SRC_W-1:0]     q_src,
    output logic                 mismatch,
    output logic                 busy,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_RDY = 2'd2,
        PUSH     = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [7:0]         shreg_reg, shreg_next;
    logic [7:0]         sent_reg, sent_next;
    logic [2:0]         bit_cnt_reg, bit_cnt_next;
    logic [SRC_W-1:0]   src_reg, src_next;
    logic [SRC_W-1:0]   last_reg, last_next;

    logic [N_REQ-1:0]   grant_reg, grant_next;
    logic               data_in_reg, data_in_next;
    logic               write_in_reg, write_in_next;
    logic               ack_reg, ack_next;
    logic               push_reg, push_next;
    logic [7:0]         q_data_reg, q_data_next;
    logic [SRC_W-1:0]   q_src_reg, q_src_next;
    logic               mismatch_reg, mismatch_next;
    logic               busy_reg, busy_next;
    logic               wdog_fire;

    logic [7:0]         req_byte [N_REQ];
    logic [N_REQ-1:0]   above_last;
    logic [N_REQ-1:0]   req_hi;
    logic [SRC_W-1:0]   win_idx;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign req_byte[gi]   = req_data[8*gi +: 8];
            assign above_last[gi] = (gi > int'(last_reg));
        end
    endgenerate

    assign req_hi = req & above_last;

    // Lowest requester above the last winner, else wrap to the lowest requester overall.
    always_comb begin
        logic found;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_hi[i] && !found) begin
                win_idx = SRC_W'(i);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && !found) begin
                win_idx = SRC_W'(i);
                found   = 1'b1;
            end
        end
    end

`ifdef DESER_LINK_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_reg, wdog_next;
    logic            timeout_reg;
`endif

    always_comb begin
        state_next    = state_reg;
        shreg_next    = shreg_reg;
        sent_next     = sent_reg;
        bit_cnt_next  = bit_cnt_reg;
        src_next      = src_reg;
        last_next     = last_reg;
        grant_next    = '0;
        data_in_next  = 1'b0;
        write_in_next = 1'b0;
        ack_next      = 1'b0;
        push_next     = 1'b0;
        q_data_next   = q_data_reg;
        q_src_next    = q_src_reg;
        mismatch_next = 1'b0;
        wdog_fire     = 1'b0;
`ifdef DESER_LINK_WDOG_EN
        wdog_next     = '0;
`endif

        case (state_reg)
            IDLE: begin
                if (|req && des_status) begin
                    // Bit 0 goes out with the grant; shreg keeps the remaining bits.
                    sent_next     = req_byte[win_idx];
                    shreg_next    = {1'b0, req_byte[win_idx][7:1]};
                    data_in_next  = req_byte[win_idx][0];
                    write_in_next = 1'b1;
                    src_next      = win_idx;
                    last_next     = win_idx;
                    grant_next    = N_REQ'(1) << win_idx;
                    bit_cnt_next  = 3'd0;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_reg == 3'd7) begin
                    state_next = WAIT_RDY;
                end else begin
                    write_in_next = 1'b1;
                    data_in_next  = shreg_reg[0];
                    shreg_next    = shreg_reg >> 1;
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                end
            end
            WAIT_RDY: begin
                if (des_data_ready && !q_full) begin
                    push_next     = 1'b1;
                    ack_next      = 1'b1;
                    q_data_next   = des_data_out;
                    q_src_next    = src_reg;
                    mismatch_next = (des_data_out != sent_reg);
                    state_next    = PUSH;
                end
`ifdef DESER_LINK_WDOG_EN
                // Backpressure (ready with queue full) freezes the watchdog.
                else if (!des_data_ready) begin
                    if (wdog_reg == WD_W'(WDOG_CYC - 1)) begin
                        wdog_fire  = 1'b1;
                        ack_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        wdog_next = wdog_reg + 1'b1;
                    end
                end else begin
                    wdog_next = wdog_reg;
                end
`endif
            end
            PUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The timeout cycle still counts as busy, mirroring the PUSH cycle.
        busy_next = (state_next != IDLE) || wdog_fire;
    end

    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            state_reg    <= IDLE;
            shreg_reg    <= '0;
            sent_reg     <= '0;
            bit_cnt_reg  <= '0;
            src_reg      <= '0;
            last_reg     <= SRC_W'(N_REQ - 1);
            grant_reg    <= '0;
            data_in_reg  <= 1'b0;
            write_in_reg <= 1'b0;
            ack_reg      <= 1'b0;
            push_reg     <= 1'b0;
            q_data_reg   <= '0;
            q_src_reg    <= '0;
            mismatch_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shreg_reg    <= shreg_next;
            sent_reg     <= sent_next;
            bit_cnt_reg  <= bit_cnt_next;
            src_reg      <= src_next;
            last_reg     <= last_next;
            grant_reg    <= grant_next;
            data_in_reg  <= data_in_next;
            write_in_reg <= write_in_next;
            ack_reg      <= ack_next;
            push_reg     <= push_next;
            q_data_reg   <= q_data_next;
            q_src_reg    <= q_src_next;
            mismatch_reg <= mismatch_next;
            busy_reg     <= busy_next;
        end
    end

`ifdef DESER_LINK_WDOG_EN
    always_ff @(posedge clock_100KHz) begin
        if (reset) begin
            wdog_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wdog_reg    <= wdog_next;
            timeout_reg <= wdog_fire;
        end
    end

    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    assign grant        = grant_reg;
    assign des_data_in  = data_in_reg;
    assign des_write_in = write_in_reg;
    assign des_ack      = ack_reg;
    assign q_push       = push_reg;
    assign q_data       = q_data_reg;
    assign q_src        = q_src_reg;
    assign mismatch     = mismatch_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_deser_link_ctrl.sv
// Scoreboard bench for deser_link_ctrl with a behavioural deserializer model.
// Watchdog scenario is compiled in when DESER_LINK_WDOG_EN is defined.
module tb_deser_link_ctrl;
    localparam int N_REQ    = 4;
    localparam int SRC_W    = 2;
    localparam int WDOG_CYC = 64;

    logic               clock_100KHz = 1'b0;
    logic               reset = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [8*N_REQ-1:0] req_data = '0;
    logic [N_REQ-1:0]   grant;
    logic               des_status;
    logic               des_data_in;
    logic               des_write_in;
    logic               des_data_ready = 1'b0;
    logic [7:0]         des_data_out = 8'h00;
    logic               des_ack;
    logic               q_full = 1'b0;
    logic               q_push;
    logic [7:0]         q_data;
    logic [SRC_W-1:0]   q_src;
    logic               mismatch;
    logic               busy;
    logic               timeout;

    always #5 clock_100KHz = ~clock_100KHz;

    deser_link_ctrl #(
        .N_REQ   (N_REQ),
        .SRC_W   (SRC_W),
        .WDOG_CYC(WDOG_CYC)
    ) dut (
        .clock_100KHz  (clock_100KHz),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .grant         (grant),
        .des_status    (des_status),
        .des_data_in   (des_data_in),
        .des_write_in  (des_write_in),
        .des_data_ready(des_data_ready),
        .des_data_out  (des_data_out),
        .des_ack       (des_ack),
        .q_full        (q_full),
        .q_push        (q_push),
        .q_data        (q_data),
        .q_src         (q_src),
        .mismatch      (mismatch),
        .busy          (busy),
        .timeout       (timeout)
    );

    typedef struct {
        logic [N_REQ-1:0] gnt;
        logic [7:0]       sent;
        logic [7:0]       data;
        logic [SRC_W-1:0] src;
        logic             mis;
        logic             to;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         last_ptr = N_REQ - 1;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    logic [7:0] corrupt_mask = 8'h00;
    bit         no_ready = 1'b0;
    bit         qf_rand = 1'b0;
    bit         qf_force = 1'b0;

    // deserializer model state
    logic [7:0] col = 8'h00;
    int         nbits = 0;
    bit         holding = 1'b0;
    int         rdy_dly = 0;
    int         wait_entry = 0;
    bit         busy_chk = 1'b0;
    logic       prev_grant = 1'b0, prev_push = 1'b0, prev_ack = 1'b0;
    logic       prev_mis = 1'b0, prev_to = 1'b0, qf_seen = 1'b0;

    assign des_status = ~holding;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected outcome from the round-robin rule: first requester after the last winner, wrapping.
    task automatic start_txn(input logic [N_REQ-1:0] r, input logic [8*N_REQ-1:0] d,
                             input logic [7:0] cmask, input bit expect_to);
        exp_t e;
        int   w;
        w = -1;
        for (int k = 1; k <= N_REQ; k++) begin
            if (w < 0 && r[(last_ptr + k) % N_REQ]) w = (last_ptr + k) % N_REQ;
        end
        last_ptr  = w;
        e.gnt     = '0;
        e.gnt[w]  = 1'b1;
        e.sent    = d[8*w +: 8];
        e.data    = e.sent ^ cmask;
        e.src     = SRC_W'(w);
        e.mis     = (cmask != 8'h00);
        e.to      = expect_to;
        exp_q.push_back(e);
        corrupt_mask = cmask;
        req_data     = d;
        req          = r;
    endtask

    task automatic wait_done(input int start, input int budget, input string name);
        int t;
        t = 0;
        while (done_cnt == start && t < budget) begin
            @(negedge clock_100KHz);
            t++;
        end
        req = '0;
        check(name, 32'(done_cnt - start), 32'd1);
    endtask

    task automatic reset_dut();
        @(negedge clock_100KHz);
        reset = 1'b1;
        repeat (2) @(negedge clock_100KHz);
        exp_q.delete();
        last_ptr = N_REQ - 1;
        reset = 1'b0;
    endtask

    // Monitor and deserializer model: one negedge process.
    always @(negedge clock_100KHz) begin
        cyc++;
        if (reset) begin
            nbits = 0;
            holding = 1'b0;
            des_data_ready = 1'b0;
            busy_chk = 1'b0;
            prev_grant = 1'b0; prev_push = 1'b0; prev_ack = 1'b0;
            prev_mis = 1'b0; prev_to = 1'b0;
        end else begin
            if (busy_chk) begin
                check("busy_after_timeout", 32'(busy), 32'd0);
                busy_chk = 1'b0;
            end
            if (|grant) begin
                check("grant_pulse", 32'(prev_grant), 32'd0);
                if (exp_q.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
                else check("grant_onehot", 32'(grant), 32'(exp_q[0].gnt));
            end
            if (des_write_in) begin
                check("busy_shift", 32'(busy), 32'd1);
                if (nbits < 8) col[nbits[2:0]] = des_data_in;
                nbits++;
            end else if (nbits > 0) begin
                check("write_len", 32'(nbits), 32'd8);
                if (exp_q.size() > 0) check("serial_bits", 32'(col), 32'(exp_q[0].sent));
                holding = 1'b1;
                rdy_dly = $urandom_range(0, 3);
                wait_entry = cyc;
                nbits = 0;
            end
            if (q_push) begin
                check("push_pulse", 32'(prev_push), 32'd0);
                check("push_gate_qfull", 32'(qf_seen), 32'd0);
                check("ack_with_push", 32'(des_ack), 32'd1);
                if (exp_q.size() == 0) begin
                    check("push_unexpected", 32'(q_push), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("push_kind", 32'(mon_e.to), 32'd0);
                    check("q_data", 32'(q_data), 32'(mon_e.data));
                    check("q_src", 32'(q_src), 32'(mon_e.src));
                    check("mismatch", 32'(mismatch), 32'(mon_e.mis));
                    $display("txn %0d: push src=%0d data=%02h mis=%0b cycle=%0d",
                             done_cnt, q_src, q_data, mismatch, cyc);
                    done_cnt++;
                end
            end else if (mismatch) begin
                check("mismatch_without_push", 32'(mismatch), 32'd0);
            end
            if (mismatch) check("mismatch_pulse", 32'(prev_mis), 32'd0);
            if (des_ack) begin
                check("ack_pulse", 32'(prev_ack), 32'd0);
                if (!q_push && !timeout) check("ack_source", 32'(des_ack), 32'd0);
            end
            if (timeout) begin
`ifdef DESER_LINK_WDOG_EN
                check("timeout_pulse", 32'(prev_to), 32'd0);
                check("ack_with_timeout", 32'(des_ack), 32'd1);
                check("no_push_on_timeout", 32'(q_push), 32'd0);
                check("timeout_latency", 32'(cyc - wait_entry), 32'(WDOG_CYC));
                if (exp_q.size() == 0) begin
                    check("timeout_unexpected", 32'(timeout), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("timeout_kind", 32'(mon_e.to), 32'd1);
                    $display("txn %0d: timeout src=%0d cycle=%0d", done_cnt, mon_e.src, cyc);
                    done_cnt++;
                    busy_chk = 1'b1;
                end
`else
                check("timeout_tied_low", 32'(timeout), 32'd0);
`endif
            end
            if (des_ack) begin
                holding = 1'b0;
                des_data_ready = 1'b0;
            end else if (holding && !des_data_ready && !no_ready) begin
                if (rdy_dly == 0) begin
                    des_data_ready = 1'b1;
                    des_data_out = col ^ corrupt_mask;
                end else begin
                    rdy_dly--;
                end
            end
            prev_grant = |grant;
            prev_push  = q_push;
            prev_ack   = des_ack;
            prev_mis   = mismatch;
            prev_to    = timeout;
        end
        q_full  = qf_rand ? ($urandom_range(0, 3) == 0) : qf_force;
        qf_seen = q_full;
    end

    initial begin
        int s;
        logic [N_REQ-1:0]   r;
        logic [8*N_REQ-1:0] d;
        logic [7:0]         m;

        repeat (3) @(negedge clock_100KHz);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_write_in", 32'(des_write_in), 32'd0);
        check("rst_q_push", 32'(q_push), 32'd0);
        check("rst_ack", 32'(des_ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;

        // single requester, A5
        s = done_cnt;
        start_txn(4'b0001, 32'h0000_00A5, 8'h00, 1'b0);
        wait_done(s, 200, "t1_done");

        // all requesters held: order 0,1,2,3,0 from a fresh pointer
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            s = done_cnt;
            start_txn(4'b1111, 32'h4433_2211, 8'h00, 1'b0);
            wait_done(s, 200, "t2_done");
        end

        // queue-full backpressure for 20 cycles
        qf_force = 1'b1;
        s = done_cnt;
        start_txn(4'b0010, 32'h0000_5A00, 8'h00, 1'b0);
        for (int t = 0; t < 100 && !des_data_ready; t++) @(negedge clock_100KHz);
        check("t3_ready_seen", 32'(des_data_ready), 32'd1);
        for (int t = 0; t < 20; t++) begin
            @(negedge clock_100KHz);
            check("t3_hold_push", 32'(q_push), 32'd0);
            check("t3_hold_ack", 32'(des_ack), 32'd0);
            check("t3_no_timeout", 32'(timeout), 32'd0);
        end
        qf_force = 1'b0;
        wait_done(s, 50, "t3_done");

        // corrupted bit 3: sends 3C, recovers 34
        s = done_cnt;
        start_txn(4'b0100, 32'h003C_0000, 8'h08, 1'b0);
        wait_done(s, 200, "t4_done");

        // reset on the 4th SHIFT cycle
        start_txn(4'b1111, 32'h9988_7766, 8'h00, 1'b0);
        for (int t = 0; t < 50 && !(|grant); t++) @(negedge clock_100KHz);
        check("t5_grant_seen", 32'(|grant), 32'd1);
        repeat (3) @(negedge clock_100KHz);
        reset = 1'b1;
        @(negedge clock_100KHz);
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_write_in", 32'(des_write_in), 32'd0);
        check("t5_data_in", 32'(des_data_in), 32'd0);
        check("t5_q_push", 32'(q_push), 32'd0);
        check("t5_ack", 32'(des_ack), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_q_data", 32'(q_data), 32'd0);
        check("t5_mismatch", 32'(mismatch), 32'd0);
        exp_q.delete();
        last_ptr = N_REQ - 1;
        req = '0;
        @(negedge clock_100KHz);
        reset = 1'b0;
        s = done_cnt;
        start_txn(4'b1111, 32'hDDCC_BBAA, 8'h00, 1'b0);
        wait_done(s, 200, "t5_done");

`ifdef DESER_LINK_WDOG_EN
        // data_ready never rises: watchdog clears the deserializer
        no_ready = 1'b1;
        s = done_cnt;
        start_txn(4'b0001, 32'h0000_00C3, 8'h00, 1'b1);
        for (int t = 0; t < 50 && !(|grant); t++) @(negedge clock_100KHz);
        req = '0;
        wait_done(s, 200, "t6_done");
        repeat (2) @(negedge clock_100KHz);
        no_ready = 1'b0;
`endif

        // randomized traffic with random backpressure and corruption
        qf_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            d = {$urandom()};
            m = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            s = done_cnt;
            start_txn(r, d, m, 1'b0);
            wait_done(s, 300, "rand_done");
        end
        qf_rand = 1'b0;
        repeat (5) @(negedge clock_100KHz);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
